// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver, 16x oversampled, majority-of-three bit
// decision. Delivers bytes on rxdw with a one-cycle rxrdy strobe. A stop bit
// sampled low raises a one-cycle ferr strobe, and the received byte is discarded.

module uart_rx_frontend #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxdw,
    output logic       rxrdy,
    output logic       ferr,
    output logic       busy
);

    // Clock cycles per sample tick, rounded to nearest, never below one.
    localparam int TICK_RAW  = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
    localparam int TICK_DIV  = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state_q,   state_d;
    logic          rxMeta_q;
    logic          rxSync_q;
    logic [TW-1:0] tickCnt_q, tickCnt_d;
    logic [3:0]    sampCnt_q, sampCnt_d;
    logic [2:0]    bitCnt_q,  bitCnt_d;
    logic          smp7_q,    smp7_d;
    logic          smp8_q,    smp8_d;
    logic [7:0]    shreg_q,   shreg_d;
    logic [7:0]    rxdw_q,    rxdw_d;
    logic          rxrdy_q,   rxrdy_d;
    logic          ferr_q,    ferr_d;

    logic          tick;
    logic          majority;

    assign tick     = (tickCnt_q == TICK_LAST);
    assign majority = (smp7_q & smp8_q) | (smp7_q & rxSync_q) | (smp8_q & rxSync_q);

    assign rxdw  = rxdw_q;
    assign rxrdy = rxrdy_q;
    assign ferr  = ferr_q;
    assign busy  = (state_q != IDLE);

    // State and datapath registers; the synchronizer idles high so reset looks like a quiet line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rxMeta_q  <= 1'b1;
            rxSync_q  <= 1'b1;
            tickCnt_q <= '0;
            sampCnt_q <= '0;
            bitCnt_q  <= '0;
            smp7_q    <= 1'b1;
            smp8_q    <= 1'b1;
            shreg_q   <= '0;
            rxdw_q    <= '0;
            rxrdy_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rxMeta_q  <= rx;
            rxSync_q  <= rxMeta_q;
            tickCnt_q <= tickCnt_d;
            sampCnt_q <= sampCnt_d;
            bitCnt_q  <= bitCnt_d;
            smp7_q    <= smp7_d;
            smp8_q    <= smp8_d;
            shreg_q   <= shreg_d;
            rxdw_q    <= rxdw_d;
            rxrdy_q   <= rxrdy_d;
            ferr_q    <= ferr_d;
        end
    end

    // Tick/sample timing, mid-bit sampling and frame sequencing.
    always_comb begin
        state_d   = state_q;
        tickCnt_d = tickCnt_q;
        sampCnt_d = sampCnt_q;
        bitCnt_d  = bitCnt_q;
        smp7_d    = smp7_q;
        smp8_d    = smp8_q;
        shreg_d   = shreg_q;
        rxdw_d    = rxdw_q;
        rxrdy_d   = 1'b0;
        ferr_d    = 1'b0;

        if (tick) begin
            tickCnt_d = '0;
            sampCnt_d = sampCnt_q + 4'd1;
            if (sampCnt_q == 4'd7) begin
                smp7_d = rxSync_q;
            end
            if (sampCnt_q == 4'd8) begin
                smp8_d = rxSync_q;
            end
        end else begin
            tickCnt_d = tickCnt_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                // Counters are held at zero here so the sample phase starts at the start edge.
                tickCnt_d = '0;
                sampCnt_d = '0;
                if (!rxSync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && sampCnt_q == 4'd9 && majority) begin
                    state_d = IDLE;
                end else if (tick && sampCnt_q == 4'd15) begin
                    state_d  = DATA;
                    bitCnt_d = 3'd0;
                end
            end
            DATA: begin
                if (tick && sampCnt_q == 4'd9) begin
                    shreg_d = {majority, shreg_q[7:1]};
                end
                if (tick && sampCnt_q == 4'd15) begin
                    if (bitCnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick && sampCnt_q == 4'd9) begin
                    if (majority) begin
                        rxdw_d  = shreg_q;
                        rxrdy_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed vectors for the UART receiver at 32 clk per bit.

module tb_uart_rx_frontend;

    localparam int BIT_CLK = 32;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rxdw;
    logic       rxrdy;
    logic       ferr;
    logic       busy;

    int totalChecks = 0;
    int badChecks   = 0;

    int         cycle     = 0;
    int         rdyCount  = 0;
    int         ferrCount = 0;
    int         bothCount = 0;
    int         wideCount = 0;
    int         rdyCycle  = 0;
    logic [7:0] lastByte  = 8'h00;
    logic       prevRdy   = 1'b0;
    logic       prevFerr  = 1'b0;
    logic       sawBusy   = 1'b0;
    int         frameStart = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         gapBits;
        logic [7:0] expRxdw;
        int         expRdyInc;
        int         expFerrInc;
    } vec_t;

    vec_t vecs[16];

    uart_rx_frontend #(
        .CLK_HZ(3_200_000),
        .BAUD  (100_000),
        .OVS   (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rxdw (rxdw),
        .rxrdy(rxrdy),
        .ferr (ferr),
        .busy (busy)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle count for latency measurement.
    always @(posedge clk) cycle++;

    // Observe the strobes away from the active edge.
    always @(negedge clk) begin
        if (rxrdy) begin
            rdyCount++;
            lastByte = rxdw;
            rdyCycle = cycle;
        end
        if (ferr) ferrCount++;
        if (rxrdy && ferr) bothCount++;
        if ((rxrdy && prevRdy) || (ferr && prevFerr)) wideCount++;
        if (busy) sawBusy = 1'b1;
        prevRdy  = rxrdy;
        prevFerr = ferr;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic holdRx(input logic val, input int nClk);
        rx = val;
        repeat (nClk) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int gapBits);
        frameStart = cycle;
        holdRx(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) holdRx(data[i], BIT_CLK);
        holdRx(stopBit, BIT_CLK);
        holdRx(1'b1, gapBits * BIT_CLK);
    endtask

    task automatic sendGlitchFrame(input logic [7:0] data, input logic [7:0] mask);
        holdRx(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                holdRx(data[i], 18);
                holdRx(~data[i], 2);
                holdRx(data[i], BIT_CLK - 20);
            end else begin
                holdRx(data[i], BIT_CLK);
            end
        end
        holdRx(1'b1, BIT_CLK);
        holdRx(1'b1, 3 * BIT_CLK);
    endtask

    initial begin
        int rdyBefore;
        int ferrBefore;
        logic [7:0] d77;

        // Frames with idle gaps, then four back-to-back frames.
        vecs[0] = '{8'h0F, 1'b1, 20, 8'h0F, 1, 0};
        for (int i = 1; i <= 11; i++) begin
            vecs[i] = '{8'(i), 1'b1, 20 + (i * 3) % 11, 8'(i), 1, 0};
        end
        vecs[12] = '{8'hA5, 1'b1, 0, 8'hA5, 1, 0};
        vecs[13] = '{8'h5A, 1'b1, 0, 8'h5A, 1, 0};
        vecs[14] = '{8'hFF, 1'b1, 0, 8'hFF, 1, 0};
        vecs[15] = '{8'h00, 1'b1, 3, 8'h00, 1, 0};

        rx  = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rxdw",  int'(rxdw),  0);
        checkOutput("reset rxrdy", int'(rxrdy), 0);
        checkOutput("reset ferr",  int'(ferr),  0);
        checkOutput("reset busy",  int'(busy),  0);
        rst = 1'b1;
        holdRx(1'b1, 2 * BIT_CLK);

        for (int v = 0; v < 16; v++) begin
            rdyBefore  = rdyCount;
            ferrBefore = ferrCount;
            applyStimulus(vecs[v].data, vecs[v].stopBit, vecs[v].gapBits);
            checkOutput($sformatf("vec%0d rdy", v), rdyCount - rdyBefore, vecs[v].expRdyInc);
            checkOutput($sformatf("vec%0d ferr", v), ferrCount - ferrBefore, vecs[v].expFerrInc);
            checkOutput($sformatf("vec%0d byte", v), int'(lastByte), int'(vecs[v].expRxdw));
            checkOutput($sformatf("vec%0d rxdw", v), int'(rxdw), int'(vecs[v].expRxdw));
            if (v == 0) begin
                checkOutput("latency window",
                            int'((rdyCycle - frameStart) >= 300 && (rdyCycle - frameStart) <= 324), 1);
            end
        end

        // Short low pulse: false start, rejected.
        rdyBefore  = rdyCount;
        ferrBefore = ferrCount;
        sawBusy    = 1'b0;
        holdRx(1'b0, 8);
        holdRx(1'b1, 60);
        checkOutput("glitch busy seen", int'(sawBusy), 1);
        checkOutput("glitch busy idle", int'(busy), 0);
        checkOutput("glitch rdy", rdyCount - rdyBefore, 0);
        checkOutput("glitch ferr", ferrCount - ferrBefore, 0);
        checkOutput("glitch rxdw", int'(rxdw), 8'h00);

        // Bad stop bit followed by a long break, then a good frame.
        rdyBefore  = rdyCount;
        ferrBefore = ferrCount;
        applyStimulus(8'h3C, 1'b0, 0);
        holdRx(1'b0, 40 * BIT_CLK);
        checkOutput("break ferr", ferrCount - ferrBefore, 1);
        checkOutput("break rdy", rdyCount - rdyBefore, 0);
        checkOutput("break rxdw", int'(rxdw), 8'h00);
        checkOutput("break busy", int'(busy), 1);
        holdRx(1'b1, 2 * BIT_CLK);
        checkOutput("break released", int'(busy), 0);
        applyStimulus(8'h11, 1'b1, 3);
        checkOutput("after break rdy", rdyCount - rdyBefore, 1);
        checkOutput("after break rxdw", int'(rxdw), 8'h11);
        checkOutput("after break ferr", ferrCount - ferrBefore, 1);

        // Two-clock glitches in the middle of ones and zeros of 8'hC3.
        rdyBefore = rdyCount;
        sendGlitchFrame(8'hC3, 8'b0110_0110);
        checkOutput("noise rdy", rdyCount - rdyBefore, 1);
        checkOutput("noise rxdw", int'(rxdw), 8'hC3);

        // Reset in the middle of bit 4 of 8'h77; line then idles.
        rdyBefore  = rdyCount;
        ferrBefore = ferrCount;
        d77 = 8'h77;
        holdRx(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) holdRx(d77[i], BIT_CLK);
        holdRx(d77[4], 16);
        checkOutput("pre-reset busy", int'(busy), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("mid reset busy",  int'(busy),  0);
        checkOutput("mid reset rxdw",  int'(rxdw),  0);
        checkOutput("mid reset rxrdy", int'(rxrdy), 0);
        checkOutput("mid reset ferr",  int'(ferr),  0);
        holdRx(1'b1, 12 * BIT_CLK);
        checkOutput("abandoned rdy", rdyCount - rdyBefore, 0);
        checkOutput("abandoned ferr", ferrCount - ferrBefore, 0);
        applyStimulus(8'h12, 1'b1, 3);
        checkOutput("post reset rdy", rdyCount - rdyBefore, 1);
        checkOutput("post reset rxdw", int'(rxdw), 8'h12);

        checkOutput("total rdy", rdyCount, 19);
        checkOutput("total ferr", ferrCount, 1);
        checkOutput("rdy and ferr overlap", bothCount, 0);
        checkOutput("strobe width", wideCount, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
